frame_stream_arbiter: RTL and testbench
=======================================

// Module: frame_stream_arbiter
// PURPOSE
//  Shares one RGB pixel stream sink (e.g. the PPM writer / display path) between two AXI4-Stream-style
//  pixel sources, granting whole frames only. Counts beats and regenerates master_last_o from
//  Height x Width, so the sink always sees correct framing. Flags source framing errors.
//  Sits between the sources (camera, test pattern) and the frame sink in sim and synthesis.
// PARAMETERS
//  Height  480  rows per frame (>=1)
//  Width   640  pixels per row (>=1)
// PORTS
//  clock_i          in   1   single clock, all logic on posedge
//  reset_i          in   1   synchronous, active-high reset
//  slave0_valid_i   in   1   source 0 beat valid
//  slave0_ready_o   out  1   source 0 beat accepted when valid&&ready
//  slave0_red_i/slave0_green_i/slave0_blue_i  in  8 each  source 0 pixel
//  slave0_last_i    in   1   source 0 end-of-frame marker
//  slave1_*         --   --  identical set for source 1
//  master_valid_o   out  1   output beat valid
//  master_ready_i   in   1   sink ready
//  master_red_o/master_green_o/master_blue_o  out  8 each  output pixel
//  master_last_o    out  1   high on beat Height*Width-1 of the frame
//  mode_i           in   2   0 = src0 only, 1 = src1 only, 2 = round-robin per frame, 3 = hold (grant none)
//  busy_o           out  1   frame in progress
//  active_source_o  out  1   source currently/last granted
//  frame_error_o    out  1   one-cycle pulse on last mismatch
//  frames_done_o    out  16  completed frame count, wraps at 65535->0
// BEHAVIOUR
//  - Reset: state IDLE, counters 0, last_served=1 (src0 wins first RR), all outputs 0.
//  - Reset mid-frame abandons the frame: no flush, no error pulse.
//  - FSM IDLE -> GRANT:
//    - Mode fixed (0/1): the selected source, once its valid is high.
//    - Mode 2: prefer !last_served if valid, else last_served if valid.
//    - Mode 3, or no eligible valid: stay IDLE.
//    - mode_i is sampled only in IDLE; changes mid-frame take effect at the next frame.
//  - Grant is registered: the first beat can transfer the cycle after the IDLE->GRANT decision.
//  - GRANT, datapath is combinational (zero latency, no buffering):
//    - master_valid_o = granted valid.
//    - granted ready = master_ready_i; the other source's ready = 0.
//    - data muxed from the granted source.
//  - In IDLE: all readies 0, master_valid_o 0.
//  - Transfer = master_valid_o && master_ready_i; column/row advance only on a transfer.
//  - Counters: column wraps Width-1->0 and increments row; row wraps Height-1->0 at frame end.
//  - master_last_o = (row==Height-1 && column==Width-1) while granted.
//  - Final transfer: GRANT -> IDLE, last_served <= granted source, frames_done_o++.
//    Exactly one idle bubble between frames.
//  - frame_error_o pulses the cycle after any transfer where slave*_last_i != computed last.
//    Early last does not truncate; late last does not extend. Framing is counter-driven.
//  - Stalls: data/valid may be held any number of cycles; counters hold.
//  - A source dropping valid mid-frame keeps the grant.
//  - busy_o = (state==GRANT). active_source_o updates on grant and holds through IDLE.
//  - Counter widths: $clog2(Width), $clog2(Height), minimum 1 bit.
// STRUCTURE
//  - video_pkg: pixel_t struct {red, green, blue : 8b}, arb_mode_e (SRC0, SRC1, ROUND_ROBIN, HOLD),
//    arb_state_e (IDLE, GRANT).
//  - Sub-module pixel_position_counter: Height/Width params; clear, advance in; column, row,
//    last_beat out. Reused by pattern generators.
// TESTING (bench params Height=2, Width=3, 6 beats/frame)
//  - Mode 0, both valid, sink always ready:
//    6 beats from src0, last on beat 6 only, frames_done_o=1, slave1_ready_o never high.
//  - Mode 2, both always valid, 3 frames:
//    served order src0, src1, src0; 1-cycle bubble between frames; frames_done_o=3.
//  - Random master_ready_i stalls:
//    output pixels match src pixels in order, no drop or duplicate, last only on 6th transfer.
//  - src0 asserts last on beat 4:
//    frame_error_o pulses once, frame still ends after beat 6.
//    No last on beat 6 -> second error pulse.
//  - reset_i on beat 3 mid-frame:
//    next cycle all outputs 0, state IDLE; next frame starts at row 0 col 0 from src0.
//  - Mode 3, and mode switch 0->1 during frame:
//    no grant in hold; the switch takes effect only after the current frame's last beat.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video types: pixel payload, arbiter mode/state encodings and width helpers.
package video_pkg;

    localparam int unsigned PIXEL_W       = 8;
    localparam int unsigned FRAME_COUNT_W = 16;

    typedef struct packed {
        logic [PIXEL_W-1:0] red;
        logic [PIXEL_W-1:0] green;
        logic [PIXEL_W-1:0] blue;
    } pixel_t;

    typedef enum logic [1:0] {
        SRC0        = 2'd0,
        SRC1        = 2'd1,
        ROUND_ROBIN = 2'd2,
        HOLD        = 2'd3
    } arb_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Counter width for a range of n values, never below one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_position_counter.sv
// Column/row position tracker for a raster frame of Height x Width beats.
// Ports:
//   clock_i    clock, all logic on posedge
//   reset_i    synchronous active-high reset
//   clear      synchronous return to row 0 / column 0
//   advance    step one beat (column first, then row)
//   column     current column
//   row        current row
//   last_beat  current position is the final beat of the frame
module pixel_position_counter
    import video_pkg::*;
#(
    parameter int unsigned Height = 480,
    parameter int unsigned Width  = 640,
    localparam int unsigned ColW  = cnt_width(Width),
    localparam int unsigned RowW  = cnt_width(Height)
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            clear,
    input  logic            advance,
    output logic [ColW-1:0] column,
    output logic [RowW-1:0] row,
    output logic            last_beat
);

    localparam logic [ColW-1:0] ColLast = ColW'(Width - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(Height - 1);

    logic col_wrap;
    logic row_wrap;

    assign col_wrap  = (column == ColLast);
    assign row_wrap  = (row == RowLast);
    assign last_beat = col_wrap && row_wrap;

    // Column wraps into the row; the row wraps back to 0 at frame end.
    always_ff @(posedge clock_i) begin
        if (reset_i || clear) begin
            column <= '0;
            row    <= '0;
        end else if (advance) begin
            if (col_wrap) begin
                column <= '0;
                row    <= row_wrap ? '0 : row + RowW'(1);
            end else begin
                column <= column + ColW'(1);
            end
        end
    end

endmodule

// File: rtl/frame_stream_arbiter.sv
// Two-source pixel stream arbiter that grants whole frames and regenerates
// end-of-frame framing from Height x Width.
// Ports:
//   clock_i, reset_i                  clock / synchronous active-high reset
//   slave{0,1}_valid_i/ready_o        source handshakes
//   slave{0,1}_{red,green,blue}_i     source pixels
//   slave{0,1}_last_i                 source end-of-frame marker (checked only)
//   master_valid_o/ready_i            sink handshake
//   master_{red,green,blue}_o         sink pixel
//   master_last_o                     regenerated end-of-frame marker
//   mode_i                            0 src0, 1 src1, 2 round-robin, 3 hold
//   busy_o                            frame in progress
//   active_source_o                   currently / last granted source
//   frame_error_o                     pulse after a beat whose source last mismatched
//   frames_done_o                     completed frame count
module frame_stream_arbiter
    import video_pkg::*;
#(
    parameter int unsigned Height = 480,
    parameter int unsigned Width  = 640
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     slave0_valid_i,
    output logic                     slave0_ready_o,
    input  logic [PIXEL_W-1:0]       slave0_red_i,
    input  logic [PIXEL_W-1:0]       slave0_green_i,
    input  logic [PIXEL_W-1:0]       slave0_blue_i,
    input  logic                     slave0_last_i,
    input  logic                     slave1_valid_i,
    output logic                     slave1_ready_o,
    input  logic [PIXEL_W-1:0]       slave1_red_i,
    input  logic [PIXEL_W-1:0]       slave1_green_i,
    input  logic [PIXEL_W-1:0]       slave1_blue_i,
    input  logic                     slave1_last_i,
    output logic                     master_valid_o,
    input  logic                     master_ready_i,
    output logic [PIXEL_W-1:0]       master_red_o,
    output logic [PIXEL_W-1:0]       master_green_o,
    output logic [PIXEL_W-1:0]       master_blue_o,
    output logic                     master_last_o,
    input  logic [1:0]               mode_i,
    output logic                     busy_o,
    output logic                     active_source_o,
    output logic                     frame_error_o,
    output logic [FRAME_COUNT_W-1:0] frames_done_o
);

    localparam int unsigned ColW = cnt_width(Width);
    localparam int unsigned RowW = cnt_width(Height);

    arb_state_e state_q, state_d;
    logic       active_q, active_d;
    logic       last_served_q;
    logic       error_q;
    logic [FRAME_COUNT_W-1:0] frames_q;

    logic       granted;
    logic       gnt_valid;
    logic       gnt_last;
    pixel_t     gnt_pix;
    pixel_t     out_pix;
    logic       xfer;
    logic       last_beat;
    logic       rr_pref_valid;
    logic [ColW-1:0] column;
    logic [RowW-1:0] row;

    pixel_position_counter #(
        .Height (Height),
        .Width  (Width)
    ) u_pos (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .clear     (state_q == IDLE),
        .advance   (xfer),
        .column    (column),
        .row       (row),
        .last_beat (last_beat)
    );

    // Zero-latency datapath: mux the granted source straight to the sink.
    always_comb begin
        granted   = (state_q == GRANT);
        gnt_valid = active_q ? slave1_valid_i : slave0_valid_i;
        gnt_last  = active_q ? slave1_last_i  : slave0_last_i;
        gnt_pix   = active_q ? pixel_t'({slave1_red_i, slave1_green_i, slave1_blue_i})
                             : pixel_t'({slave0_red_i, slave0_green_i, slave0_blue_i});
        out_pix   = granted ? gnt_pix : '0;
        master_valid_o = granted && gnt_valid;
        master_last_o  = granted && last_beat;
        slave0_ready_o = granted && !active_q && master_ready_i;
        slave1_ready_o = granted &&  active_q && master_ready_i;
        xfer           = master_valid_o && master_ready_i;
    end

    assign master_red_o    = out_pix.red;
    assign master_green_o  = out_pix.green;
    assign master_blue_o   = out_pix.blue;
    assign busy_o          = (state_q == GRANT);
    assign active_source_o = active_q;
    assign frame_error_o   = error_q;
    assign frames_done_o   = frames_q;

    // Round-robin favours the source that was not served last.
    assign rr_pref_valid = last_served_q ? slave0_valid_i : slave1_valid_i;

    // Next-state: pick a source in IDLE, release after the counter's final beat.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        unique case (state_q)
            IDLE: begin
                unique case (arb_mode_e'(mode_i))
                    SRC0: if (slave0_valid_i) begin
                        state_d  = GRANT;
                        active_d = 1'b0;
                    end
                    SRC1: if (slave1_valid_i) begin
                        state_d  = GRANT;
                        active_d = 1'b1;
                    end
                    ROUND_ROBIN: if (rr_pref_valid) begin
                        state_d  = GRANT;
                        active_d = !last_served_q;
                    end else if (slave0_valid_i || slave1_valid_i) begin
                        state_d  = GRANT;
                        active_d = last_served_q;
                    end
                    default: ;
                endcase
            end
            GRANT: if (xfer && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            active_q      <= 1'b0;
            last_served_q <= 1'b1;
            frames_q      <= '0;
            error_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            error_q  <= xfer && (gnt_last != last_beat);
            if (xfer && last_beat) begin
                last_served_q <= active_q;
                frames_q      <= frames_q + FRAME_COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_frame_stream_arbiter.sv
// Directed bench for frame_stream_arbiter with a 2 x 3 frame.
module tb_frame_stream_arbiter;

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       slave0_valid_i = 1'b0, slave1_valid_i = 1'b0;
    logic       slave0_ready_o, slave1_ready_o;
    logic [7:0] slave0_red_i = '0, slave0_green_i = '0, slave0_blue_i = '0;
    logic [7:0] slave1_red_i = '0, slave1_green_i = '0, slave1_blue_i = '0;
    logic       slave0_last_i = 1'b0, slave1_last_i = 1'b0;
    logic       master_valid_o, master_ready_i = 1'b0;
    logic [7:0] master_red_o, master_green_o, master_blue_o;
    logic       master_last_o;
    logic [1:0] mode_i = 2'd0;
    logic       busy_o, active_source_o, frame_error_o;
    logic [15:0] frames_done_o;

    int n_cmp = 0;
    int n_err = 0;
    int s_cnt [2] = '{0, 0};

    frame_stream_arbiter #(.Height(2), .Width(3)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .slave0_valid_i(slave0_valid_i), .slave0_ready_o(slave0_ready_o),
        .slave0_red_i(slave0_red_i), .slave0_green_i(slave0_green_i),
        .slave0_blue_i(slave0_blue_i), .slave0_last_i(slave0_last_i),
        .slave1_valid_i(slave1_valid_i), .slave1_ready_o(slave1_ready_o),
        .slave1_red_i(slave1_red_i), .slave1_green_i(slave1_green_i),
        .slave1_blue_i(slave1_blue_i), .slave1_last_i(slave1_last_i),
        .master_valid_o(master_valid_o), .master_ready_i(master_ready_i),
        .master_red_o(master_red_o), .master_green_o(master_green_o),
        .master_blue_o(master_blue_o), .master_last_o(master_last_o),
        .mode_i(mode_i), .busy_o(busy_o), .active_source_o(active_source_o),
        .frame_error_o(frame_error_o), .frames_done_o(frames_done_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pix(input bit s, input int c);
        logic [7:0] cb;
        cb = 8'(c);
        return {s, cb[6:0], cb ^ 8'h5A, 8'hFF - cb};
    endfunction

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // Present beats k_start..k_end-1 of a frame expected from source exp_src.
    task automatic run_frame(input bit exp_src, input int stall_pct, input int last_at,
                             input int k_start, input int k_end, input string tag);
        int k;
        int guard;
        logic [23:0] exp_pix;
        bit exp_err;
        k = k_start;
        guard = 0;
        while (k < k_end && guard < 200) begin
            {slave0_red_i, slave0_green_i, slave0_blue_i} = pix(1'b0, s_cnt[0]);
            {slave1_red_i, slave1_green_i, slave1_blue_i} = pix(1'b1, s_cnt[1]);
            slave0_last_i  = (k == last_at);
            slave1_last_i  = (k == last_at);
            master_ready_i = ($urandom_range(0, 99) >= stall_pct);
            #1;
            check({tag, "_other_ready"}, exp_src ? slave0_ready_o : slave1_ready_o, 0);
            if (master_valid_o && master_ready_i) begin
                exp_pix = pix(exp_src, s_cnt[exp_src]);
                check({tag, "_own_ready"}, exp_src ? slave1_ready_o : slave0_ready_o, 1);
                check({tag, "_pixel"}, {master_red_o, master_green_o, master_blue_o}, exp_pix);
                check({tag, "_last"}, master_last_o, (k == 5));
                exp_err = ((k == last_at) != (k == 5));
                tick();
                check({tag, "_frame_error"}, frame_error_o, exp_err);
                s_cnt[exp_src]++;
                k++;
            end else begin
                tick();
                check({tag, "_no_error"}, frame_error_o, 0);
            end
            guard++;
        end
        if (k < k_end) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_timeout: observed %0d beats expected %0d", tag, k, k_end);
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    initial begin
        // Reset state.
        do_reset();
        check("rst_busy", busy_o, 0);
        check("rst_valid", master_valid_o, 0);
        check("rst_ready0", slave0_ready_o, 0);
        check("rst_ready1", slave1_ready_o, 0);
        check("rst_frames", frames_done_o, 0);
        check("rst_active", active_source_o, 0);
        check("rst_error", frame_error_o, 0);

        // Mode 0, both valid, sink always ready.
        slave0_valid_i = 1'b1;
        slave1_valid_i = 1'b1;
        mode_i = 2'd0;
        run_frame(1'b0, 0, 5, 0, 6, "m0");
        check("m0_frames", frames_done_o, 1);
        check("m0_busy_end", busy_o, 0);
        check("m0_active", active_source_o, 0);

        // Round-robin from reset: src0, src1, src0 with one bubble between.
        do_reset();
        mode_i = 2'd2;
        run_frame(1'b0, 0, 5, 0, 6, "rr0");
        check("rr0_bubble", busy_o, 0);
        tick();
        check("rr1_busy", busy_o, 1);
        check("rr1_active", active_source_o, 1);
        run_frame(1'b1, 0, 5, 0, 6, "rr1");
        check("rr1_bubble", busy_o, 0);
        tick();
        check("rr2_busy", busy_o, 1);
        check("rr2_active", active_source_o, 0);
        run_frame(1'b0, 0, 5, 0, 6, "rr2");
        check("rr_frames", frames_done_o, 3);

        // Random sink stalls.
        mode_i = 2'd0;
        run_frame(1'b0, 40, 5, 0, 6, "stall_a");
        run_frame(1'b0, 40, 5, 0, 6, "stall_b");
        check("stall_frames", frames_done_o, 5);

        // Early source last on beat 4, none on beat 6.
        run_frame(1'b0, 0, 3, 0, 6, "early");
        check("early_frames", frames_done_o, 6);
        check("early_busy_end", busy_o, 0);

        // Hold mode grants nothing.
        mode_i = 2'd3;
        master_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_busy", busy_o, 0);
            check("hold_valid", master_valid_o, 0);
            check("hold_ready", {slave0_ready_o, slave1_ready_o}, 0);
        end

        // Mode switch 0 -> 1 mid-frame applies only after the frame ends.
        mode_i = 2'd0;
        run_frame(1'b0, 0, 5, 0, 3, "sw_a");
        mode_i = 2'd1;
        run_frame(1'b0, 0, 5, 3, 6, "sw_b");
        check("sw_idle", busy_o, 0);
        check("sw_active_hold", active_source_o, 0);
        tick();
        check("sw_busy", busy_o, 1);
        check("sw_active", active_source_o, 1);
        run_frame(1'b1, 0, 5, 0, 6, "sw_c");
        check("sw_frames", frames_done_o, 8);

        // Reset while beat 3 is on the bus.
        mode_i = 2'd0;
        run_frame(1'b0, 0, 5, 0, 2, "mid_a");
        master_ready_i = 1'b1;
        reset_i = 1'b1;
        tick();
        check("mid_busy", busy_o, 0);
        check("mid_valid", master_valid_o, 0);
        check("mid_ready0", slave0_ready_o, 0);
        check("mid_frames", frames_done_o, 0);
        check("mid_error", frame_error_o, 0);
        check("mid_active", active_source_o, 0);
        reset_i = 1'b0;
        run_frame(1'b0, 0, 5, 0, 6, "mid_b");
        check("mid_frames_after", frames_done_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
